eval_scheduler: RTL and testbench

Population evaluation scheduler that sits in front of the datapath router's per-thread port side. It dispatches one EVAL instruction per genome index 0..genome_count-1 across THREADS router ports and collects each fitness result as it finishes. Results stream out on a valid/ready port, and a done pulse marks the end of the generation.

---
 rtl/eval_scheduler_pkg.sv | 33 +++
 rtl/eval_slot.sv | 84 ++++++++
 rtl/eval_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_eval_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eval_scheduler_pkg.sv
// eval_scheduler_pkg: instruction/result widths, EVAL opcode placement and FSM state types
// shared by the population evaluation scheduler and its per-thread slots.
`default_nettype none

package eval_scheduler_pkg;

  localparam int INSTRUCTION_WIDTH = 16;
  localparam int RESULT_WIDTH      = 16;
  localparam int OPCODE_W          = 4;
  localparam int OPCODE_LSB        = 12;
  localparam logic [OPCODE_W-1:0] OP_EVAL = 4'h5;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_BUSY  = 2'd2,
    SLOT_HELD  = 2'd3
  } slot_state_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } top_state_e;

  function automatic logic [INSTRUCTION_WIDTH-1:0] make_eval(input logic [OPCODE_LSB-1:0] operand);
    make_eval = {OP_EVAL, operand};
  endfunction

endpackage

`default_nettype wire

// File: rtl/eval_slot.sv
// eval_slot: one router port's issue/complete/hand-off tracker; drives that port's
// instruction and start, captures its result and owning genome until drained.
`default_nettype none

module eval_slot
  import eval_scheduler_pkg::*;
#(
  parameter int GENOME_W = 12
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         issue_i,
  input  logic [GENOME_W-1:0]          genome_i,
  input  logic                         finished_i,
  input  logic [RESULT_WIDTH-1:0]      result_i,
  input  logic                         drain_i,
  output logic                         free_o,
  output logic                         held_o,
  output logic                         start_o,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_o,
  output logic [GENOME_W-1:0]          genome_o,
  output logic [RESULT_WIDTH-1:0]      result_o
);

  slot_state_e               state_q, state_d;
  logic [GENOME_W-1:0]       genome_q, genome_d;
  logic [RESULT_WIDTH-1:0]   result_q, result_d;
  logic [OPCODE_LSB-1:0]     operand;

  always_comb begin
    state_d  = state_q;
    genome_d = genome_q;
    result_d = result_q;
    case (state_q)
      SLOT_FREE: begin
        if (issue_i) begin
          state_d  = SLOT_ARMED;
          genome_d = genome_i;
        end
      end
      // The router still shows its previous finished level here, so it is ignored.
      SLOT_ARMED: state_d = SLOT_BUSY;
      SLOT_BUSY: begin
        if (finished_i) begin
          state_d  = SLOT_HELD;
          result_d = result_i;
        end
      end
      SLOT_HELD: begin
        if (drain_i) state_d = SLOT_FREE;
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= SLOT_FREE;
      genome_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      genome_q <= genome_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    operand = '0;
    if (issue_i) operand[GENOME_W-1:0] = genome_i;
    else         operand[GENOME_W-1:0] = genome_q;
    instruction_o = '0;
    if (issue_i || (state_q != SLOT_FREE)) instruction_o = make_eval(operand);
  end

  assign free_o   = (state_q == SLOT_FREE);
  assign held_o   = (state_q == SLOT_HELD);
  assign start_o  = issue_i && (state_q == SLOT_FREE);
  assign genome_o = genome_q;
  assign result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/eval_scheduler.sv
// eval_scheduler: dispatches EVAL per genome over THREADS router ports and streams fitness
// results out on valid/ready. Optional EVAL_SCHED_BEST_TRACK_EN adds best_fitness/best_genome.
`default_nettype none

module eval_scheduler
  import eval_scheduler_pkg::*;
#(
  parameter int THREADS  = 4,
  parameter int GENOME_W = 12
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 go,
  input  logic [GENOME_W-1:0]                  genome_count,
  output logic                                 busy,
  output logic                                 done,
  output logic [INSTRUCTION_WIDTH*THREADS-1:0] instruction,
  output logic [THREADS-1:0]                   start,
  input  logic [RESULT_WIDTH*THREADS-1:0]      result,
  input  logic [THREADS-1:0]                   finished,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [GENOME_W-1:0]                  res_genome,
`ifdef EVAL_SCHED_BEST_TRACK_EN
  output logic [RESULT_WIDTH-1:0]              best_fitness,
  output logic [GENOME_W-1:0]                  best_genome,
`endif
  output logic [RESULT_WIDTH-1:0]              res_fitness
);

  localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

  top_state_e              state_q, state_d;
  logic [GENOME_W-1:0]     count_q, count_d;
  logic [GENOME_W-1:0]     next_q, next_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic                    valid_q, valid_d;
  logic [GENOME_W-1:0]     rgen_q, rgen_d;
  logic [RESULT_WIDTH-1:0] rfit_q, rfit_d;

  logic [THREADS-1:0]      slot_free, slot_held, issue_vec, drain_vec;
  logic [GENOME_W-1:0]     slot_genome [THREADS];
  logic [RESULT_WIDTH-1:0] slot_result [THREADS];
  logic                    issue_any, pick_any, load, accept;
  logic [IDX_W-1:0]        pick_idx, cand;

  // Lowest-index free slot takes the next genome.
  always_comb begin
    issue_vec = '0;
    issue_any = 1'b0;
    if ((state_q == ST_RUN) && (next_q != count_q)) begin
      for (int i = 0; i < THREADS; i++) begin
        if (slot_free[i] && !issue_any) begin
          issue_vec[i] = 1'b1;
          issue_any    = 1'b1;
        end
      end
    end
  end

  // Round-robin search over held slots, starting just after the last drained one.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = rr_q;
    cand     = '0;
    for (int k = 1; k <= THREADS; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % THREADS);
      if (!pick_any && slot_held[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
    accept    = valid_q && res_ready;
    load      = pick_any && (!valid_q || res_ready);
    drain_vec = '0;
    if (load) drain_vec[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    next_d  = next_q + GENOME_W'(issue_any);
    rr_d    = rr_q;
    valid_d = valid_q;
    rgen_d  = rgen_q;
    rfit_d  = rfit_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          count_d = genome_count;
          next_d  = '0;
          // An empty generation passes through an already-empty DRAIN on its way to DONE.
          state_d = (genome_count != '0) ? ST_RUN : ST_DRAIN;
        end
      end
      ST_RUN:   if (next_d == count_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((&slot_free) && !valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (load) begin
      valid_d = 1'b1;
      rgen_d  = slot_genome[pick_idx];
      rfit_d  = slot_result[pick_idx];
      rr_d    = pick_idx;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      next_q  <= '0;
      rr_q    <= IDX_W'(THREADS - 1);
      valid_q <= 1'b0;
      rgen_q  <= '0;
      rfit_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      next_q  <= next_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      rgen_q  <= rgen_d;
      rfit_q  <= rfit_d;
    end
  end

  for (genvar i = 0; i < THREADS; i++) begin : g_slot
    eval_slot #(
      .GENOME_W(GENOME_W)
    ) u_slot (
      .clock        (clock),
      .resetn       (resetn),
      .issue_i      (issue_vec[i]),
      .genome_i     (next_q),
      .finished_i   (finished[i]),
      .result_i     (result[i*RESULT_WIDTH +: RESULT_WIDTH]),
      .drain_i      (drain_vec[i]),
      .free_o       (slot_free[i]),
      .held_o       (slot_held[i]),
      .start_o      (start[i]),
      .instruction_o(instruction[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH]),
      .genome_o     (slot_genome[i]),
      .result_o     (slot_result[i])
    );
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign res_valid   = valid_q;
  assign res_genome  = rgen_q;
  assign res_fitness = rfit_q;

`ifdef EVAL_SCHED_BEST_TRACK_EN
  logic [RESULT_WIDTH-1:0] best_fit_q, best_fit_d;
  logic [GENOME_W-1:0]     best_gen_q, best_gen_d;

  // Strictly-greater compare keeps the earlier genome on ties.
  always_comb begin
    best_fit_d = best_fit_q;
    best_gen_d = best_gen_q;
    if ((state_q == ST_IDLE) && go) begin
      best_fit_d = '0;
      best_gen_d = '0;
    end else if (accept && (rfit_q > best_fit_q)) begin
      best_fit_d = rfit_q;
      best_gen_d = rgen_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      best_fit_q <= '0;
      best_gen_q <= '0;
    end else begin
      best_fit_q <= best_fit_d;
      best_gen_q <= best_gen_d;
    end
  end

  assign best_fitness = best_fit_q;
  assign best_genome  = best_gen_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eval_scheduler.sv
// tb_eval_scheduler: directed scenarios against a latency-programmable router model.
`default_nettype none

module tb_eval_scheduler;
  import eval_scheduler_pkg::*;

  localparam int T  = 4;
  localparam int GW = 12;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int RW = RESULT_WIDTH;

  logic            clock = 1'b0;
  logic            resetn, go, res_ready;
  logic [GW-1:0]   genome_count;
  logic            busy, done, res_valid;
  logic [IW*T-1:0] instruction;
  logic [T-1:0]    start, finished;
  logic [RW*T-1:0] result;
  logic [GW-1:0]   res_genome;
  logic [RW-1:0]   res_fitness;
`ifdef EVAL_SCHED_BEST_TRACK_EN
  logic [RW-1:0]   best_fitness;
  logic [GW-1:0]   best_genome;
`endif

  eval_scheduler #(.THREADS(T), .GENOME_W(GW)) dut (
    .clock(clock), .resetn(resetn), .go(go), .genome_count(genome_count),
    .busy(busy), .done(done), .instruction(instruction), .start(start),
    .result(result), .finished(finished), .res_valid(res_valid),
    .res_ready(res_ready), .res_genome(res_genome),
`ifdef EVAL_SCHED_BEST_TRACK_EN
    .best_fitness(best_fitness), .best_genome(best_genome),
`endif
    .res_fitness(res_fitness)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Router model: finished drops the cycle after start and rises lat cycles after start.
  int          lat [T];
  int          rcnt [T];
  logic [RW-1:0] fit_tab [16];
  always @(posedge clock) begin
    for (int i = 0; i < T; i++) begin
      if (!resetn) begin
        finished[i] <= 1'b1;
        rcnt[i]     <= 0;
        result[i*RW +: RW] <= '0;
      end else if (start[i]) begin
        finished[i] <= 1'b0;
        rcnt[i]     <= lat[i] - 1;
        result[i*RW +: RW] <= fit_tab[instruction[i*IW +: 4]];
      end else if (rcnt[i] > 1) begin
        rcnt[i] <= rcnt[i] - 1;
      end else if (rcnt[i] == 1) begin
        rcnt[i]     <= 0;
        finished[i] <= 1'b1;
      end
    end
  end

  // Event logs sampled mid-cycle.
  int          st_slot[$];
  int          st_cyc[$];
  logic [IW-1:0] st_instr[$];
  int          hs_gen[$];
  int          hs_fit[$];
  int          hs_cyc[$];
  int          valid_seen;
  always @(negedge clock) begin
    if (resetn) begin
      for (int i = 0; i < T; i++) begin
        if (start[i]) begin
          st_slot.push_back(i);
          st_cyc.push_back(cyc);
          st_instr.push_back(instruction[i*IW +: IW]);
        end
      end
      if (res_valid) valid_seen++;
      if (res_valid && res_ready) begin
        hs_gen.push_back(int'(res_genome));
        hs_fit.push_back(int'(res_fitness));
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    st_slot.delete(); st_cyc.delete(); st_instr.delete();
    hs_gen.delete(); hs_fit.delete(); hs_cyc.delete();
    valid_seen = 0;
  endtask

  task automatic set_router(input int l0, input int l1, input int l2, input int l3,
                            input int base, input int step);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    for (int g = 0; g < 16; g++) fit_tab[g] = RW'(base + g * step);
  endtask

  task automatic pulse_go(input int count, output int gcyc);
    genome_count = GW'(count);
    go   = 1'b1;
    gcyc = cyc;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, bound);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; go = 1'b0; res_ready = 1'b1; genome_count = '0;
    set_router(5, 5, 5, 5, 0, 1);
    tick(3);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", done); end
    compared++; if (start !== '0) begin mismatched++; $display("FAIL reset_start: got %h required 0", start); end
    compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    compared++; if (instruction !== '0) begin mismatched++; $display("FAIL reset_instruction: got %h required 0", instruction); end
    compared++; if (res_genome !== '0 || res_fitness !== '0) begin
      mismatched++; $display("FAIL reset_res_data: got %h/%h required 0/0", res_genome, res_fitness);
    end
    resetn = 1'b1;
    tick(1);
    clear_logs();
  endtask

  // Slots 1 and 3 complete together; pointer is fresh from reset so slot 1 drains first.
  task automatic test_round_robin();
    int g;
    int exp_gen[4];
    exp_gen = '{1, 3, 0, 2};
    set_router(10, 4, 10, 2, 100, 1);
    pulse_go(4, g);
    wait_done(100, "rr");
    tick(2);
    compared++; if (hs_gen.size() != 4) begin mismatched++; $display("FAIL rr_count: got %0d results required 4", hs_gen.size()); end
    for (int k = 0; k < 4 && k < hs_gen.size(); k++) begin
      compared++;
      if (hs_gen[k] != exp_gen[k] || hs_fit[k] != 100 + exp_gen[k]) begin
        mismatched++;
        $display("FAIL rr_order%0d: got genome %0d fit %0d required genome %0d fit %0d", k, hs_gen[k], hs_fit[k], exp_gen[k], 100 + exp_gen[k]);
      end
    end
    if (hs_cyc.size() == 4) begin
      compared++;
      if (hs_cyc[0] != g + 8 || hs_cyc[1] != g + 9) begin
        mismatched++;
        $display("FAIL rr_timing: got cycles %0d,%0d required %0d,%0d", hs_cyc[0] - g, hs_cyc[1] - g, 8, 9);
      end
    end
    clear_logs();
  endtask

  task automatic test_basic();
    int g, gdone, dummy;
    set_router(5, 5, 5, 5, 1, 7);
    pulse_go(3, g);
    tick(1);
    pulse_go(7, dummy);
    wait_done(100, "basic");
    gdone = cyc;
    compared++; if (gdone != g + 12) begin mismatched++; $display("FAIL basic_done_cycle: got +%0d required +12", gdone - g); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_at_done: got %b required 0", busy); end
    tick(3);
    compared++; if (st_slot.size() != 3) begin mismatched++; $display("FAIL basic_start_count: got %0d required 3", st_slot.size()); end
    for (int k = 0; k < 3 && k < st_slot.size(); k++) begin
      compared++;
      if (st_slot[k] != k || st_cyc[k] != g + 1 + k || st_instr[k] !== (16'h5000 | 16'(k))) begin
        mismatched++;
        $display("FAIL basic_start%0d: got slot %0d cyc +%0d instr %h required slot %0d cyc +%0d instr %h",
                 k, st_slot[k], st_cyc[k] - g, st_instr[k], k, k + 1, 16'h5000 | 16'(k));
      end
    end
    compared++; if (hs_gen.size() != 3) begin mismatched++; $display("FAIL basic_result_count: got %0d required 3", hs_gen.size()); end
    for (int k = 0; k < 3 && k < hs_gen.size(); k++) begin
      compared++;
      if (hs_gen[k] != k || hs_fit[k] != 1 + 7 * k) begin
        mismatched++;
        $display("FAIL basic_result%0d: got genome %0d fit %0d required genome %0d fit %0d", k, hs_gen[k], hs_fit[k], k, 1 + 7 * k);
      end
    end
    clear_logs();
  endtask

  task automatic test_zero_count();
    int g;
    pulse_go(0, g);
    wait_done(10, "zero");
    compared++; if (cyc != g + 2) begin mismatched++; $display("FAIL zero_done_cycle: got +%0d required +2", cyc - g); end
    tick(3);
    compared++; if (st_slot.size() != 0) begin mismatched++; $display("FAIL zero_starts: got %0d required 0", st_slot.size()); end
    compared++; if (valid_seen != 0) begin mismatched++; $display("FAIL zero_res_valid: got %0d valid cycles required 0", valid_seen); end
    clear_logs();
  endtask

  task automatic test_backpressure();
    int g;
    logic [15:0] seen;
    res_ready = 1'b0;
    set_router(3, 3, 3, 3, 200, 5);
    pulse_go(10, g);
    tick(49);
    compared++; if (st_slot.size() != 5) begin mismatched++; $display("FAIL bp_stall_starts: got %0d required 5", st_slot.size()); end
    compared++; if (res_valid !== 1'b1 || res_genome !== GW'(0)) begin
      mismatched++; $display("FAIL bp_stall_head: got valid %b genome %0d required valid 1 genome 0", res_valid, res_genome);
    end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL bp_stall_busy: got %b required 1", busy); end
    res_ready = 1'b1;
    wait_done(300, "bp");
    tick(3);
    compared++; if (hs_gen.size() != 10) begin mismatched++; $display("FAIL bp_result_count: got %0d required 10", hs_gen.size()); end
    compared++; if (st_slot.size() != 10) begin mismatched++; $display("FAIL bp_start_count: got %0d required 10", st_slot.size()); end
    seen = '0;
    for (int k = 0; k < hs_gen.size(); k++) begin
      compared++;
      if (hs_gen[k] > 9 || seen[hs_gen[k]] || hs_fit[k] != 200 + 5 * hs_gen[k]) begin
        mismatched++;
        $display("FAIL bp_result%0d: got genome %0d fit %0d (dup=%b) required unique genome<10 fit %0d",
                 k, hs_gen[k], hs_fit[k], (hs_gen[k] <= 9) ? seen[hs_gen[k]] : 1'b0, 200 + 5 * hs_gen[k]);
      end
      if (hs_gen[k] <= 9) seen[hs_gen[k]] = 1'b1;
    end
    clear_logs();
  endtask

  task automatic test_mid_reset();
    int g;
    set_router(5, 5, 5, 5, 50, 1);
    pulse_go(10, g);
    tick(4);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mrst_busy_before: got %b required 1", busy); end
    resetn = 1'b0;
    tick(1);
    compared++; if (start !== '0) begin mismatched++; $display("FAIL mrst_start: got %h required 0", start); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mrst_busy: got %b required 0", busy); end
    compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL mrst_res_valid: got %b required 0", res_valid); end
    resetn = 1'b1;
    tick(1);
    clear_logs();
    pulse_go(2, g);
    wait_done(100, "mrst");
    tick(3);
    compared++;
    if (st_slot.size() < 1 || st_slot[0] != 0 || st_cyc[0] != g + 1 || st_instr[0] !== 16'h5000) begin
      mismatched++;
      $display("FAIL mrst_restart: got %0d starts first slot %0d instr %h required slot 0 instr 5000 at +1",
               st_slot.size(), (st_slot.size() > 0) ? st_slot[0] : -1, (st_instr.size() > 0) ? st_instr[0] : 16'h0);
    end
    compared++;
    if (hs_gen.size() != 2 || hs_gen[0] != 0 || hs_gen[1] != 1) begin
      mismatched++; $display("FAIL mrst_results: got %0d results required genomes 0,1", hs_gen.size());
    end
    clear_logs();
  endtask

`ifdef EVAL_SCHED_BEST_TRACK_EN
  task automatic test_best();
    int g;
    set_router(5, 5, 5, 5, 0, 0);
    fit_tab[0] = 7; fit_tab[1] = 9; fit_tab[2] = 9; fit_tab[3] = 2;
    pulse_go(4, g);
    compared++; if (best_fitness !== '0 || best_genome !== '0) begin
      mismatched++; $display("FAIL best_clear: got %0d/%0d required 0/0", best_fitness, best_genome);
    end
    wait_done(100, "best");
    compared++; if (best_fitness !== RW'(9)) begin mismatched++; $display("FAIL best_fitness: got %0d required 9", best_fitness); end
    compared++; if (best_genome !== GW'(1)) begin mismatched++; $display("FAIL best_genome: got %0d required 1", best_genome); end
    tick(2);
    clear_logs();
  endtask
`endif

  initial begin
    valid_seen = 0;
    test_reset();
    test_round_robin();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_mid_reset();
`ifdef EVAL_SCHED_BEST_TRACK_EN
    test_best();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
